// File: rtl/or1k_branch_resolver_if.sv
// Branch resolver port bundle: decode-side push, execute-side resolve, and redirect/status returns.
// master = pipeline driving the resolver, slave = the resolver itself.
interface or1k_branch_resolver_if #(
  parameter int OPTION_OPERAND_WIDTH = 32
);
  logic                            padv_decode_i;
  logic                            op_bf_i;
  logic                            op_bnf_i;
  logic                            predicted_flag_i;
  logic [OPTION_OPERAND_WIDTH-1:0] decode_pc_i;
  logic [OPTION_OPERAND_WIDTH-1:0] decode_target_i;
  logic                            padv_execute_i;
  logic                            flag_i;
  logic                            pipeline_flush_i;

  logic                            execute_op_bf_o;
  logic                            execute_op_bnf_o;
  logic                            prev_op_brcond_o;
  logic                            branch_mispredict_o;
  logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o;
  logic [OPTION_OPERAND_WIDTH-1:0] brn_pc_o;
  logic                            stall_o;
  logic [31:0]                     stat_branches_o;
  logic [31:0]                     stat_mispredicts_o;

  modport master (
    output padv_decode_i, op_bf_i, op_bnf_i, predicted_flag_i,
           decode_pc_i, decode_target_i, padv_execute_i, flag_i,
           pipeline_flush_i,
    input  execute_op_bf_o, execute_op_bnf_o, prev_op_brcond_o,
           branch_mispredict_o, redirect_pc_o, brn_pc_o, stall_o,
           stat_branches_o, stat_mispredicts_o
  );

  modport slave (
    input  padv_decode_i, op_bf_i, op_bnf_i, predicted_flag_i,
           decode_pc_i, decode_target_i, padv_execute_i, flag_i,
           pipeline_flush_i,
    output execute_op_bf_o, execute_op_bnf_o, prev_op_brcond_o,
           branch_mispredict_o, redirect_pc_o, brn_pc_o, stall_o,
           stat_branches_o, stat_mispredicts_o
  );
endinterface

// File: rtl/or1k_branch_resolver.sv
// In-flight conditional branch queue: predictions pushed at decode, resolved against SR[F] at execute.
// Optional performance counters enabled by defining OR1K_BRANCH_RESOLVER_STATS_EN.
module or1k_branch_resolver #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int QUEUE_DEPTH          = 4
) (
  input logic                clk,
  input logic                rst,
  or1k_branch_resolver_if.slave bif
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int W     = OPTION_OPERAND_WIDTH;

  // Entry payload, split per field; never reset since count qualifies validity.
  logic         bf_q   [QUEUE_DEPTH];
  logic         bnf_q  [QUEUE_DEPTH];
  logic         pred_q [QUEUE_DEPTH];
  logic [W-1:0] pc_q   [QUEUE_DEPTH];
  logic [W-1:0] tgt_q  [QUEUE_DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic         prev_brcond;
  logic         mispredict;
  logic [W-1:0] redirect_pc;

  logic         empty;
  logic         full;
  logic         is_branch;
  logic         push;
  logic         pop;
  logic         head_bf;
  logic         head_bnf;
  logic         head_pred;
  logic [W-1:0] head_pc;
  logic [W-1:0] head_tgt;
  logic         head_taken;
  logic         head_mispredict;
  logic [W-1:0] head_redirect;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(QUEUE_DEPTH));
  assign is_branch = bif.op_bf_i | bif.op_bnf_i;
  assign pop       = bif.padv_execute_i & ~empty;
  // A push into a full queue is only accepted when the head retires on the same edge.
  assign push      = bif.padv_decode_i & is_branch & (~full | pop);

  assign head_bf   = bf_q[rd_ptr];
  assign head_bnf  = bnf_q[rd_ptr];
  assign head_pred = pred_q[rd_ptr];
  assign head_pc   = pc_q[rd_ptr];
  assign head_tgt  = tgt_q[rd_ptr];

  assign head_taken      = (head_bf & bif.flag_i) | (head_bnf & ~bif.flag_i);
  assign head_mispredict = head_taken ^ head_pred;
  // Not-taken path resumes after the delay slot; wraps modulo the PC width.
  assign head_redirect   = head_taken ? head_tgt : head_pc + W'(8);

  always_ff @(posedge clk) begin
    if (push) begin
      bf_q[wr_ptr]   <= bif.op_bf_i;
      bnf_q[wr_ptr]  <= bif.op_bnf_i;
      pred_q[wr_ptr] <= bif.predicted_flag_i;
      pc_q[wr_ptr]   <= bif.decode_pc_i;
      tgt_q[wr_ptr]  <= bif.decode_target_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      prev_brcond <= 1'b0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      prev_brcond <= 1'b0;
      mispredict  <= 1'b0;
      if (bif.pipeline_flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (pop) begin
          prev_brcond <= 1'b1;
          mispredict  <= head_mispredict;
          redirect_pc <= head_redirect;
        end
        if (pop && head_mispredict) begin
          // Wrong path: every younger entry and any same-cycle push is discarded.
          rd_ptr <= '0;
          wr_ptr <= '0;
          count  <= '0;
        end else begin
          if (push) wr_ptr <= wr_ptr + PTR_W'(1);
          if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
          if (push && !pop)      count <= count + CNT_W'(1);
          else if (!push && pop) count <= count - CNT_W'(1);
        end
      end
    end
  end

`ifdef OR1K_BRANCH_RESOLVER_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  // Saturating counters; a flush suppresses the pop so it is never counted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (!bif.pipeline_flush_i && pop) begin
      if (stat_branches != '1)
        stat_branches <= stat_branches + 32'd1;
      if (head_mispredict && stat_mispredicts != '1)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end

  assign bif.stat_branches_o    = stat_branches;
  assign bif.stat_mispredicts_o = stat_mispredicts;
`else
  assign bif.stat_branches_o    = '0;
  assign bif.stat_mispredicts_o = '0;
`endif

  assign bif.execute_op_bf_o     = ~empty & head_bf;
  assign bif.execute_op_bnf_o    = ~empty & head_bnf;
  assign bif.brn_pc_o            = empty ? '0 : head_pc;
  assign bif.stall_o             = full;
  assign bif.prev_op_brcond_o    = prev_brcond;
  assign bif.branch_mispredict_o = mispredict;
  assign bif.redirect_pc_o       = redirect_pc;

endmodule

// File: tb/tb_or1k_branch_resolver.sv
// Directed bench for or1k_branch_resolver; counter expectations follow OR1K_BRANCH_RESOLVER_STATS_EN.
module tb_or1k_branch_resolver;

`ifdef OR1K_BRANCH_RESOLVER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  or1k_branch_resolver_if #(.OPTION_OPERAND_WIDTH(32)) bif ();

  or1k_branch_resolver #(.OPTION_OPERAND_WIDTH(32), .QUEUE_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] st(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  task automatic idle();
    bif.padv_decode_i    = 1'b0;
    bif.op_bf_i          = 1'b0;
    bif.op_bnf_i         = 1'b0;
    bif.predicted_flag_i = 1'b0;
    bif.decode_pc_i      = '0;
    bif.decode_target_i  = '0;
    bif.padv_execute_i   = 1'b0;
    bif.flag_i           = 1'b0;
    bif.pipeline_flush_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input bit bf, input bit pred, input logic [31:0] pc, input logic [31:0] tgt);
    bif.padv_decode_i    = 1'b1;
    bif.op_bf_i          = bf;
    bif.op_bnf_i         = ~bf;
    bif.predicted_flag_i = pred;
    bif.decode_pc_i      = pc;
    bif.decode_target_i  = tgt;
  endtask

  task automatic set_pop(input bit flag);
    bif.padv_execute_i = 1'b1;
    bif.flag_i         = flag;
  endtask

  task automatic push_one(input bit bf, input bit pred, input logic [31:0] pc, input logic [31:0] tgt);
    idle();
    set_push(bf, pred, pc, tgt);
    step();
    idle();
  endtask

  task automatic pop_one(input bit flag);
    idle();
    set_pop(flag);
    step();
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    rst = 1'b0;
    step();
    step();

    // Reset state
    check("rst_stall", 32'(bif.stall_o), 32'd0);
    check("rst_brcond", 32'(bif.prev_op_brcond_o), 32'd0);
    check("rst_mispredict", 32'(bif.branch_mispredict_o), 32'd0);
    check("rst_redirect", bif.redirect_pc_o, 32'h0);
    check("rst_brn_pc", bif.brn_pc_o, 32'h0);
    check("rst_exec_bf", 32'(bif.execute_op_bf_o), 32'd0);
    check("rst_stat_br", bif.stat_branches_o, 32'd0);

    rst = 1'b1;
    step();

    // l.bf predicted taken, resolves taken
    push_one(1'b1, 1'b1, 32'h100, 32'h200);
    check("bf_head_type", 32'(bif.execute_op_bf_o), 32'd1);
    check("bf_head_pc", bif.brn_pc_o, 32'h100);
    pop_one(1'b1);
    check("bf_brcond", 32'(bif.prev_op_brcond_o), 32'd1);
    check("bf_mispredict", 32'(bif.branch_mispredict_o), 32'd0);
    check("bf_redirect", bif.redirect_pc_o, 32'h200);
    check("bf_stat_br", bif.stat_branches_o, st(1));
    check("bf_empty_type", 32'(bif.execute_op_bf_o), 32'd0);
    step();
    check("bf_pulse_end", 32'(bif.prev_op_brcond_o), 32'd0);
    check("bf_redirect_hold", bif.redirect_pc_o, 32'h200);

    // l.bnf predicted taken, flag=1 means not taken -> mispredict to pc+8
    push_one(1'b0, 1'b1, 32'h100, 32'h40);
    check("bnf_head_type", 32'(bif.execute_op_bnf_o), 32'd1);
    pop_one(1'b1);
    check("bnf_brcond", 32'(bif.prev_op_brcond_o), 32'd1);
    check("bnf_mispredict", 32'(bif.branch_mispredict_o), 32'd1);
    check("bnf_redirect", bif.redirect_pc_o, 32'h108);
    check("bnf_stat_mis", bif.stat_mispredicts_o, st(1));
    check("bnf_stat_br", bif.stat_branches_o, st(2));

    // Fill to depth, overflow push ignored, push+pop while full
    for (int i = 1; i <= 4; i++) begin
      check("fill_stall_before", 32'(bif.stall_o), 32'd0);
      push_one(1'b1, 1'b1, 32'(i * 16), 32'(i * 16 + 32'h1000));
    end
    check("full_stall", 32'(bif.stall_o), 32'd1);
    push_one(1'b1, 1'b1, 32'h50, 32'h1050);
    check("overflow_stall", 32'(bif.stall_o), 32'd1);
    check("overflow_head", bif.brn_pc_o, 32'h10);
    idle();
    set_push(1'b1, 1'b1, 32'h60, 32'h1060);
    set_pop(1'b1);
    step();
    idle();
    check("full_pushpop_stall", 32'(bif.stall_o), 32'd1);
    check("full_pushpop_head", bif.brn_pc_o, 32'h20);
    check("full_pushpop_brcond", 32'(bif.prev_op_brcond_o), 32'd1);
    check("full_pushpop_mis", 32'(bif.branch_mispredict_o), 32'd0);
    check("full_pushpop_redir", bif.redirect_pc_o, 32'h1010);
    pop_one(1'b1);
    check("drain1_head", bif.brn_pc_o, 32'h30);
    check("drain1_stall", 32'(bif.stall_o), 32'd0);
    pop_one(1'b1);
    check("drain2_head", bif.brn_pc_o, 32'h40);
    pop_one(1'b1);
    check("drain3_head", bif.brn_pc_o, 32'h60);
    pop_one(1'b1);
    check("drain4_head", bif.brn_pc_o, 32'h0);
    check("drain4_redir", bif.redirect_pc_o, 32'h1060);
    check("drain_stat_br", bif.stat_branches_o, st(7));

    // Head mispredict discards younger entries and a same-cycle push
    push_one(1'b0, 1'b0, 32'h300, 32'h400);
    push_one(1'b0, 1'b0, 32'h304, 32'h400);
    push_one(1'b0, 1'b0, 32'h308, 32'h400);
    check("three_head", bif.brn_pc_o, 32'h300);
    idle();
    set_push(1'b0, 1'b0, 32'h30C, 32'h400);
    set_pop(1'b0);
    step();
    idle();
    check("squash_mis", 32'(bif.branch_mispredict_o), 32'd1);
    check("squash_redir", bif.redirect_pc_o, 32'h400);
    check("squash_bf", 32'(bif.execute_op_bf_o), 32'd0);
    check("squash_bnf", 32'(bif.execute_op_bnf_o), 32'd0);
    check("squash_brn_pc", bif.brn_pc_o, 32'h0);
    check("squash_stat_mis", bif.stat_mispredicts_o, st(2));
    pop_one(1'b0);
    check("empty_pop_brcond", 32'(bif.prev_op_brcond_o), 32'd0);
    check("empty_pop_stat", bif.stat_branches_o, st(8));

    // Flush with concurrent pop: no pulse, queue emptied
    push_one(1'b1, 1'b1, 32'h500, 32'h600);
    push_one(1'b1, 1'b1, 32'h504, 32'h604);
    idle();
    set_pop(1'b1);
    bif.pipeline_flush_i = 1'b1;
    step();
    idle();
    check("flush_brcond", 32'(bif.prev_op_brcond_o), 32'd0);
    check("flush_mis", 32'(bif.branch_mispredict_o), 32'd0);
    check("flush_brn_pc", bif.brn_pc_o, 32'h0);
    check("flush_exec_bf", 32'(bif.execute_op_bf_o), 32'd0);
    check("flush_stat_br", bif.stat_branches_o, st(8));

    // Reset mid-operation overrides push and pop
    push_one(1'b1, 1'b1, 32'h700, 32'h800);
    push_one(1'b1, 1'b0, 32'h704, 32'h804);
    pop_one(1'b1);
    check("pre_rst_brcond", 32'(bif.prev_op_brcond_o), 32'd1);
    idle();
    set_push(1'b1, 1'b1, 32'h708, 32'h808);
    set_pop(1'b1);
    rst = 1'b0;
    step();
    idle();
    check("mid_rst_brcond", 32'(bif.prev_op_brcond_o), 32'd0);
    check("mid_rst_mis", 32'(bif.branch_mispredict_o), 32'd0);
    check("mid_rst_redir", bif.redirect_pc_o, 32'h0);
    check("mid_rst_brn_pc", bif.brn_pc_o, 32'h0);
    check("mid_rst_stall", 32'(bif.stall_o), 32'd0);
    check("mid_rst_stat_br", bif.stat_branches_o, 32'd0);
    check("mid_rst_stat_mis", bif.stat_mispredicts_o, 32'd0);
    rst = 1'b1;
    step();

    // Not-taken mispredict at top of address space wraps
    push_one(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h800);
    pop_one(1'b0);
    check("wrap_mis", 32'(bif.branch_mispredict_o), 32'd1);
    check("wrap_redir", bif.redirect_pc_o, 32'h0000_0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/or1k_branch_resolver.md
OR1K_BRANCH_RESOLVER -- requirements
Module: or1k_branch_resolver

Interface
REQ-001 Parameter OPTION_OPERAND_WIDTH, default 32, PC/target width.
REQ-002 Parameter QUEUE_DEPTH, default 4, in-flight prediction entries; power of two, 2..16.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-005 padv_decode_i  input  1  decode stage advances this cycle.
REQ-006 op_bf_i / op_bnf_i  input  1 each  decode insn is l.bf / l.bnf (never both).
REQ-007 predicted_flag_i  input  1  predictor verdict for the decode insn (1 = taken).
REQ-008 decode_pc_i / decode_target_i  input  OPTION_OPERAND_WIDTH each  branch PC and taken target.
REQ-009 padv_execute_i  input  1  execute stage advances; resolves queue head.
REQ-010 flag_i  input  1  architectural SR[F] at execute.
REQ-011 pipeline_flush_i  input  1  external flush (exception/rfe).
REQ-012 execute_op_bf_o / execute_op_bnf_o  output  1 each  type of valid queue head, 0 when empty.
REQ-013 prev_op_brcond_o  output  1  one-cycle pulse: a conditional branch resolved last edge.
REQ-014 branch_mispredict_o  output  1  one-cycle pulse with prev_op_brcond_o: prediction wrong.
REQ-015 redirect_pc_o  output  OPTION_OPERAND_WIDTH  correct fetch PC, valid while branch_mispredict_o=1.
REQ-016 brn_pc_o  output  OPTION_OPERAND_WIDTH  PC of queue head, 0 when empty.
REQ-017 stall_o  output  1  queue full; decode must not issue a further branch.
REQ-018 stat_branches_o / stat_mispredicts_o  output  32 each  performance counters.

Function
REQ-019 Entry = {bf, bnf, predicted, pc, target}; FIFO with wrapping read/write pointers and count of width clog2(QUEUE_DEPTH)+1.
REQ-020 Push on padv_decode_i & (op_bf_i|op_bnf_i) & !stall_o; push while full is ignored, state unchanged.
REQ-021 stall_o = (count == QUEUE_DEPTH), combinational from count.
REQ-022 Pop on padv_execute_i & count!=0; padv_execute_i with empty queue has no effect, no pulse.
REQ-023 On pop: taken = (bf & flag_i) | (bnf & !flag_i); register prev_op_brcond_o=1, branch_mispredict_o = taken ^ predicted.
REQ-024 redirect_pc_o registered = taken ? target : pc + 8 (delay slot), modulo 2^OPTION_OPERAND_WIDTH.
REQ-025 Pulses last exactly one cycle; redirect_pc_o holds value until next pop.
REQ-026 Simultaneous push and pop (no mispredict): both performed, count unchanged, works when full and when count=1.
REQ-027 Pop that mispredicts: all remaining entries and any same-cycle push are discarded (count=0 next cycle).
REQ-028 pipeline_flush_i: count=0 next cycle, same-cycle push/pop discarded, no pulses generated; pulses from previous edge still complete.
REQ-029 Resolution latency: flag_i sampled at pop edge, pulses visible the following cycle.

Reset
REQ-030 While rst=0 at an edge: pointers, count = 0; prev_op_brcond_o, branch_mispredict_o = 0; redirect_pc_o = 0; counters = 0.
REQ-031 Reset overrides push, pop and flush in the same cycle; entry payload storage needs no reset.

Configuration
REQ-032 Macro OR1K_BRANCH_RESOLVER_STATS_EN defined: stat_branches_o increments per pop, stat_mispredicts_o per mispredict, both saturate at 0xFFFFFFFF, flush does not clear them.
REQ-033 Macro undefined: counters not instantiated, both outputs constant 0; all other behaviour identical.

Verification
REQ-034 Push l.bf pc=0x100 target=0x200 predicted=1, pop with flag_i=1 -> prev_op_brcond_o=1, mispredict=0, stat_branches_o=1.
REQ-035 Push l.bnf pc=0x100 target=0x40 predicted=1, pop with flag_i=1 -> mispredict=1, redirect_pc_o=0x108, stat_mispredicts_o=1.
REQ-036 Push 4 branches (depth 4) -> stall_o=1; 5th push ignored; simultaneous push+pop while full -> count stays 4, stall_o=1.
REQ-037 Three entries queued, head mispredicts -> count=0 next cycle, execute_op_bf_o=execute_op_bnf_o=0, brn_pc_o=0.
REQ-038 pipeline_flush_i with 2 entries and concurrent pop -> no pulse, count=0; rst=0 mid-operation -> all outputs 0 next cycle.
REQ-039 pc=0xFFFFFFFC not-taken mispredict -> redirect_pc_o=0x00000004 (wrap-around).
